// File: rtl/tlm_xmit_sched_pkg.sv
// tlm_xmit_pkg: shared state encodings for the batch scheduler and its ping-pong banks.
package tlm_xmit_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_e;
  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_e;
endpackage

// File: rtl/tlm_xmit_sched_bank.sv
// tlm_pair_bank: one ping-pong bank of NUM operand pairs with its own occupancy state.
//  clk_i/reset_i  clock, async active-low reset
//  clr_i          run start: force EMPTY
//  req_i          batch requested for this bank: EMPTY -> FILLING
//  wr_en_i        write wr_data_i at wr_idx_i; last index makes the bank FULL
//  rd_en_i        pair at rd_idx_i loaded downstream; last index frees the bank
//  rd_data_o      async read of rd_idx_i
//  state_o        current bank state
module tlm_pair_bank import tlm_xmit_pkg::*; #(
  parameter int NUM = 1000,
  parameter int ITEM_WIDTH = 8,
  parameter int IDX_W = 10
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clr_i,
  input  logic                    req_i,
  input  logic                    wr_en_i,
  input  logic [IDX_W-1:0]        wr_idx_i,
  input  logic [2*ITEM_WIDTH-1:0] wr_data_i,
  input  logic                    rd_en_i,
  input  logic [IDX_W-1:0]        rd_idx_i,
  output logic [2*ITEM_WIDTH-1:0] rd_data_o,
  output bank_state_e             state_o
);
  logic [2*ITEM_WIDTH-1:0] mem_q [NUM];
  bank_state_e state_q, state_d;
  logic wr_last, rd_last;
  assign wr_last = wr_idx_i == IDX_W'(NUM - 1);
  assign rd_last = rd_idx_i == IDX_W'(NUM - 1);
  assign rd_data_o = mem_q[rd_idx_i];
  assign state_o = state_q;
  // Request, fill and drain only ever target a bank in EMPTY, FILLING and FULL/DRAINING
  // respectively, so at most one of them is active per cycle and the order is immaterial.
  always_comb
    state_d = clr_i ? B_EMPTY :
              req_i ? B_FILLING :
              (wr_en_i && wr_last) ? B_FULL :
              rd_en_i ? (rd_last ? B_EMPTY : B_DRAINING) : state_q;
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) state_q <= B_EMPTY;
    else state_q <= state_d;
  always_ff @(posedge clk_i)
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
endmodule

// File: rtl/tlm_xmit_sched.sv
// tlm_xmit_sched: requests CYCLE_NUM batches of NUM (A,B) pairs into two ping-pong banks
// and drains them in order to the bfm under valid/ready flow control.
//  clk_i/reset_i          clock, async active-low reset
//  start_i                begin a run (IDLE or DONE only)
//  batch_req_o            1-cycle pulse: producer owes NUM pairs
//  wr_valid_i/wr_ready_o  producer handshake, wr_a_i/wr_b_i payload
//  xmit_en_o/dn_ready_i   downstream handshake, A_s/B_s payload
//  batch_cnt_o            batches fully accepted downstream this run
//  busy_o/done_o          running / run complete (sticky)
module tlm_xmit_sched import tlm_xmit_pkg::*; #(
  parameter int NUM = 1000,
  parameter int ITEM_WIDTH = 8,
  parameter int CYCLE_NUM = 2000,
  localparam int IDX_W = $clog2(NUM),
  localparam int BCNT_W = $clog2(CYCLE_NUM + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic                  batch_req_o,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [ITEM_WIDTH-1:0] wr_a_i,
  input  logic [ITEM_WIDTH-1:0] wr_b_i,
  output logic                  xmit_en_o,
  input  logic                  dn_ready_i,
  output logic [ITEM_WIDTH-1:0] A_s,
  output logic [ITEM_WIDTH-1:0] B_s,
  output logic [BCNT_W-1:0]     batch_cnt_o,
  output logic                  busy_o,
  output logic                  done_o
);
  sched_state_e state_q;
  logic busy_q, done_q;
  logic req_bank_q, req_bank_d, fill_bank_q, fill_bank_d, drain_bank_q, drain_bank_d;
  logic [IDX_W-1:0] fill_idx_q, fill_idx_d, drain_idx_q, drain_idx_d;
  logic [BCNT_W-1:0] req_cnt_q, req_cnt_d, bcnt_q, bcnt_d;
  logic xmit_q, xmit_d, last_q, last_d;
  logic [ITEM_WIDTH-1:0] a_q, a_d, b_q, b_d;
  bank_state_e bst [2];
  logic [2*ITEM_WIDTH-1:0] rd_data [2];
  logic [2*ITEM_WIDTH-1:0] sel;
  logic run, start, req, wr, load, accept, fill_last, drain_last;
  assign run = state_q == RUN;
  assign start = start_i && !run;
  assign req = run && bst[req_bank_q] == B_EMPTY && req_cnt_q < BCNT_W'(CYCLE_NUM);
  assign wr_ready_o = bst[fill_bank_q] == B_FILLING;
  assign wr = wr_valid_i && wr_ready_o;
  assign accept = xmit_q && dn_ready_i;
  assign load = run && (bst[drain_bank_q] == B_FULL || bst[drain_bank_q] == B_DRAINING) &&
                (!xmit_q || dn_ready_i);
  assign fill_last = fill_idx_q == IDX_W'(NUM - 1);
  assign drain_last = drain_idx_q == IDX_W'(NUM - 1);
  assign sel = rd_data[drain_bank_q];
  assign batch_req_o = req;
  assign xmit_en_o = xmit_q;
  assign A_s = a_q;
  assign B_s = b_q;
  assign batch_cnt_o = bcnt_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  for (genvar g = 0; g < 2; g++) begin : g_bank
    tlm_pair_bank #(.NUM(NUM), .ITEM_WIDTH(ITEM_WIDTH), .IDX_W(IDX_W)) u_bank (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .clr_i     (start),
      .req_i     (req && req_bank_q == 1'(g)),
      .wr_en_i   (wr && fill_bank_q == 1'(g)),
      .wr_idx_i  (fill_idx_q),
      .wr_data_i ({wr_a_i, wr_b_i}),
      .rd_en_i   (load && drain_bank_q == 1'(g)),
      .rd_idx_i  (drain_idx_q),
      .rd_data_o (rd_data[g]),
      .state_o   (bst[g])
    );
  end
  // last_q marks that the pair on A_s/B_s closes its batch, so its acceptance counts the batch.
  always_comb begin
    req_bank_d = start ? 1'b0 : req_bank_q ^ req;
    req_cnt_d = start ? '0 : req_cnt_q + BCNT_W'(req);
    fill_idx_d = start ? '0 : wr ? (fill_last ? '0 : fill_idx_q + 1'b1) : fill_idx_q;
    fill_bank_d = start ? 1'b0 : fill_bank_q ^ (wr && fill_last);
    drain_idx_d = start ? '0 : load ? (drain_last ? '0 : drain_idx_q + 1'b1) : drain_idx_q;
    drain_bank_d = start ? 1'b0 : drain_bank_q ^ (load && drain_last);
    xmit_d = start ? 1'b0 : load ? 1'b1 : accept ? 1'b0 : xmit_q;
    a_d = start ? '0 : load ? sel[2*ITEM_WIDTH-1:ITEM_WIDTH] : a_q;
    b_d = start ? '0 : load ? sel[ITEM_WIDTH-1:0] : b_q;
    last_d = start ? 1'b0 : load ? drain_last : last_q;
    bcnt_d = start ? '0 : (accept && last_q && bcnt_q != BCNT_W'(CYCLE_NUM)) ? bcnt_q + 1'b1 : bcnt_q;
  end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      state_q <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      state_q <= RUN;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else if (run && bcnt_q == BCNT_W'(CYCLE_NUM) && !xmit_q) begin
      state_q <= DONE;
      busy_q <= 1'b0;
      done_q <= 1'b1;
    end
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      req_bank_q <= 1'b0;
      req_cnt_q <= '0;
      fill_idx_q <= '0;
      fill_bank_q <= 1'b0;
      drain_idx_q <= '0;
      drain_bank_q <= 1'b0;
      xmit_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      last_q <= 1'b0;
      bcnt_q <= '0;
    end else begin
      req_bank_q <= req_bank_d;
      req_cnt_q <= req_cnt_d;
      fill_idx_q <= fill_idx_d;
      fill_bank_q <= fill_bank_d;
      drain_idx_q <= drain_idx_d;
      drain_bank_q <= drain_bank_d;
      xmit_q <= xmit_d;
      a_q <= a_d;
      b_q <= b_d;
      last_q <= last_d;
      bcnt_q <= bcnt_d;
    end
endmodule

// File: tb/tb_tlm_xmit_sched.sv
// tb_tlm_xmit_sched: randomized and directed checks of tlm_xmit_sched against a counter-level model.
module tb_tlm_xmit_sched;
  localparam int N = 4, C = 3, W = 8;
  logic clk_i = 0, reset_i = 0, start_i = 0, wr_valid_i = 0, dn_ready_i = 0;
  logic [W-1:0] wr_a_i = 0, wr_b_i = 0;
  logic batch_req_o, wr_ready_o, xmit_en_o, busy_o, done_o;
  logic [W-1:0] A_s, B_s;
  logic [1:0] batch_cnt_o;

  tlm_xmit_sched #(.NUM(N), .ITEM_WIDTH(W), .CYCLE_NUM(C)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .batch_req_o(batch_req_o),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_a_i(wr_a_i), .wr_b_i(wr_b_i),
    .xmit_en_o(xmit_en_o), .dn_ready_i(dn_ready_i), .A_s(A_s), .B_s(B_s),
    .batch_cnt_o(batch_cnt_o), .busy_o(busy_o), .done_o(done_o));

  always #5 clk_i = ~clk_i;

  int tests = 0, fails = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: whole run described by totals of requested, written, loaded and accepted pairs.
  int writes, loads, accs, reqs;
  bit run_m, done_m, mx;
  logic [15:0] mpair;
  logic [15:0] wq[$];
  logic [15:0] acc_log[$];
  int dut_reqs;

  function automatic bit exp_req();
    return run_m && reqs < C && (reqs - loads / N) < 2;
  endfunction
  function automatic bit exp_wr_ready();
    return run_m && writes < reqs * N;
  endfunction
  function automatic int exp_bcnt();
    return (accs / N > C) ? C : accs / N;
  endfunction

  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      writes = 0; loads = 0; accs = 0; reqs = 0;
      run_m = 0; done_m = 0; mx = 0; mpair = 0;
      wq.delete();
    end else begin
      automatic bit er = exp_req();
      automatic bit ewr = exp_wr_ready();
      automatic bit acc = mx && dn_ready_i;
      automatic int avail = (writes / N) * N - loads;
      automatic bit ld = run_m && avail > 0 && (!mx || dn_ready_i);
      automatic int old_b = exp_bcnt();
      automatic bit old_x = mx;
      if (batch_req_o) dut_reqs++;
      if (xmit_en_o && dn_ready_i) acc_log.push_back({A_s, B_s});
      if (ewr && wr_valid_i) begin
        wq.push_back({wr_a_i, wr_b_i});
        writes++;
      end
      if (acc) accs++;
      if (ld) begin
        mpair = wq[loads];
        loads++;
        mx = 1;
      end else if (acc) mx = 0;
      if (er) reqs++;
      if (!run_m && start_i) begin
        writes = 0; loads = 0; accs = 0; reqs = 0;
        run_m = 1; done_m = 0; mx = 0;
        wq.delete();
      end else if (run_m && old_b == C && !old_x) begin
        run_m = 0;
        done_m = 1;
      end
    end
  end

  always @(negedge clk_i)
    if (reset_i) begin
      chk("xmit_en", 32'(xmit_en_o), 32'(mx));
      if (mx) chk("pair", {16'h0, A_s, B_s}, {16'h0, mpair});
      chk("batch_cnt", 32'(batch_cnt_o), 32'(exp_bcnt()));
      chk("busy", 32'(busy_o), 32'(run_m));
      chk("done", 32'(done_o), 32'(done_m));
      chk("batch_req", 32'(batch_req_o), 32'(exp_req()));
      chk("wr_ready", 32'(wr_ready_o), 32'(exp_wr_ready()));
    end

  // Producer/consumer driver: producer holds pair p until accepted.
  int dn_mode = 0, limit = 0;
  bit vrand = 0;
  int p = 0;
  bit rdy_s = 0;
  always @(negedge clk_i)
    if (!reset_i) begin
      p = 0; rdy_s = 0; wr_valid_i = 0;
    end else begin
      if (!busy_o) p = 0;
      else if (wr_valid_i && rdy_s) p++;
      rdy_s = wr_ready_o;
      wr_valid_i = (p < limit) && (!vrand || $urandom_range(0, 1) == 1);
      wr_a_i = 8'(p);
      wr_b_i = 8'(p + 'h80);
      dn_ready_i = dn_mode == 0 ? 1'b1 : dn_mode == 1 ? ~dn_ready_i :
                   dn_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
    end

  task automatic cyc(int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask
  task automatic pulse_start();
    start_i = 1; cyc(1); start_i = 0;
  endtask
  task automatic wait_done(int maxc);
    int k = 0;
    while (!done_o && k < maxc) begin cyc(1); k++; end
    chk("done_reached", 32'(done_o), 1);
  endtask
  task automatic check_log(string name);
    chk({name, "_count"}, acc_log.size(), 12);
    for (int k = 0; k < 12 && k < acc_log.size(); k++)
      chk(name, 32'(acc_log[k]), 32'({8'(k), 8'(k + 'h80)}));
  endtask
  task automatic new_run(int mode, int lim, bit vr);
    dn_mode = mode; limit = lim; vrand = vr;
    acc_log.delete(); dut_reqs = 0;
    pulse_start();
  endtask

  initial begin
    cyc(3);
    reset_i = 1;
    cyc(10);
    chk("idle_xmit", 32'(xmit_en_o), 0);
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_done", 32'(done_o), 0);
    chk("idle_bcnt", 32'(batch_cnt_o), 0);
    chk("idle_wr_ready", 32'(wr_ready_o), 0);
    chk("idle_reqs", dut_reqs, 0);
    // stream, dn_ready high
    new_run(0, 12, 0);
    wait_done(300);
    check_log("s2_pair");
    chk("s2_reqs", dut_reqs, 3);
    chk("s2_bcnt", 32'(batch_cnt_o), 3);
    // dn_ready toggling, started from DONE
    new_run(1, 12, 0);
    chk("s3_done_cleared", 32'(done_o), 0);
    wait_done(300);
    check_log("s3_pair");
    chk("s3_reqs", dut_reqs, 3);
    // both banks fill while downstream stalls
    new_run(2, 8, 0);
    cyc(30);
    chk("s4_wr_ready", 32'(wr_ready_o), 0);
    chk("s4_reqs", dut_reqs, 2);
    chk("s4_xmit", 32'(xmit_en_o), 1);
    chk("s4_first", {16'h0, A_s, B_s}, 32'h0080);
    cyc(5);
    chk("s4_reqs_hold", dut_reqs, 2);
    dn_mode = 0; limit = 12;
    wait_done(300);
    chk("s4_reqs_final", dut_reqs, 3);
    check_log("s4_pair");
    // reset mid-run, then restart
    new_run(0, 12, 0);
    begin
      int k = 0;
      while (acc_log.size() < 6 && k < 300) begin cyc(1); k++; end
      chk("s5_reached6", acc_log.size() >= 6, 1);
    end
    reset_i = 0;
    #1;
    chk("s5_rst_xmit", 32'(xmit_en_o), 0);
    chk("s5_rst_ab", {16'h0, A_s, B_s}, 0);
    chk("s5_rst_busy", 32'(busy_o), 0);
    chk("s5_rst_bcnt", 32'(batch_cnt_o), 0);
    chk("s5_rst_req", 32'(batch_req_o), 0);
    chk("s5_rst_wr_ready", 32'(wr_ready_o), 0);
    chk("s5_rst_done", 32'(done_o), 0);
    cyc(2);
    reset_i = 1;
    cyc(1);
    new_run(0, 12, 0);
    wait_done(300);
    check_log("s5_pair");
    // start during RUN ignored, start in DONE restarts
    new_run(0, 12, 0);
    begin
      int k = 0;
      while (batch_cnt_o != 1 && k < 300) begin cyc(1); k++; end
    end
    pulse_start();
    chk("s6_bcnt_kept", 32'(batch_cnt_o), 1);
    chk("s6_busy", 32'(busy_o), 1);
    wait_done(300);
    check_log("s6_pair");
    pulse_start();
    chk("s6_restart_done", 32'(done_o), 0);
    chk("s6_restart_busy", 32'(busy_o), 1);
    wait_done(300);
    // random valid and ready
    for (int r = 0; r < 4; r++) begin
      new_run(3, 12, 1);
      wait_done(1000);
      check_log("rnd_pair");
      chk("rnd_reqs", dut_reqs, 3);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
